// File: rtl/pim_seq_ctrl_if.sv
// Command/response handshake bundle between a CFU-style host and the PIM sequencer.
// The master drives commands and accepts responses; the slave is the sequencer.
interface pim_seq_ctrl_if;
  localparam int unsigned OPW = 3;
  localparam int unsigned XW  = 32;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [OPW-1:0] cmd_function_id;
  logic [XW-1:0]  cmd_inputs_0;
  logic [XW-1:0]  cmd_inputs_1;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [XW-1:0]  rsp_outputs_0;
  logic           rsp_error;

  modport master (
    output cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_outputs_0, rsp_error
  );

  modport slave (
    input  cmd_valid, cmd_function_id, cmd_inputs_0, cmd_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_outputs_0, rsp_error
  );
endinterface

// File: rtl/pim_seq_ctrl.sv
// Sequencer that turns CFU commands into PIM macro pin sequences (write, read,
// activation load, bit-serial MAC) and returns the result on a valid/ready channel.
module pim_seq_ctrl #(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned PDEPTH = 1 << AWIDTH,
  parameter int unsigned PWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned ABITS  = 4,
  parameter int unsigned DRAIN  = 2
) (
  input  logic                clk,
  input  logic                reset,
  pim_seq_ctrl_if.slave       cfu,
  output logic [PWIDTH-1:0]   pim_d,
  output logic [AWIDTH-1:0]   pim_addr,
  output logic [PDEPTH-1:0]   pim_rwl,
  output logic                pim_w_en,
  output logic                pim_p_en,
  input  logic [PWIDTH-1:0]   pim_q,
  input  logic [DWIDTH-1:0]   pim_mac_out
);

  localparam int unsigned XW   = 32;
  localparam int unsigned MAXC = (ABITS > DRAIN) ? ABITS : DRAIN;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_RD     = 3'd2;
  localparam logic [2:0] S_RD_CAP = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;
  localparam logic [2:0] S_CAP    = 3'd6;
  localparam logic [2:0] S_RESP   = 3'd7;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_SET   = 3'd2;
  localparam logic [2:0] OP_RUN   = 3'd3;
  localparam logic [2:0] OP_CLR   = 3'd4;

  logic [2:0]        state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [CW-1:0]     sel;
  logic [ABITS-1:0]  act [PDEPTH];
  logic [PDEPTH-1:0] plane;
  logic              act_set, act_clr;

  logic              cmd_ready_n, rsp_valid_n, rsp_error_n;
  logic [XW-1:0]     rsp_out_n;
  logic [PWIDTH-1:0] pim_d_n;
  logic [AWIDTH-1:0] pim_addr_n;
  logic [PDEPTH-1:0] pim_rwl_n;
  logic              pim_w_en_n, pim_p_en_n;

  logic [AWIDTH-1:0] row;
  logic              unused_bits;

  // Row index wraps: only the low AWIDTH bits of operand 0 select a row.
  assign row         = cfu.cmd_inputs_0[AWIDTH-1:0];
  assign unused_bits = &{1'b0, cfu.cmd_inputs_0};

  // Bit-plane `sel` of every row's activation, one bit per read wordline.
  always_comb begin
    logic [ABITS-1:0] sh;
    plane = '0;
    sh    = '0;
    for (int j = 0; j < int'(PDEPTH); j++) begin
      sh       = act[j] >> sel;
      plane[j] = sh[0];
    end
  end

  // Activation buffer: written at the accept edge of SET_ACT / CLR_ACT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < int'(PDEPTH); j++) act[j] <= '0;
    end else if (act_clr) begin
      for (int j = 0; j < int'(PDEPTH); j++) act[j] <= '0;
    end else if (act_set) begin
      act[row] <= cfu.cmd_inputs_1[ABITS-1:0];
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sel         = '0;
    act_set     = 1'b0;
    act_clr     = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_error_n = cfu.rsp_error;
    rsp_out_n   = cfu.rsp_outputs_0;
    pim_d_n     = pim_d;
    pim_addr_n  = pim_addr;
    pim_rwl_n   = '0;
    pim_w_en_n  = 1'b0;
    pim_p_en_n  = 1'b0;

    case (state)
      S_IDLE: begin
        if (cfu.cmd_valid && cfu.cmd_ready) begin
          rsp_error_n = 1'b0;
          rsp_out_n   = '0;
          cnt_n       = '0;
          case (cfu.cmd_function_id)
            OP_WRITE: begin
              state_n    = S_WR;
              pim_w_en_n = 1'b1;
              pim_addr_n = row;
              pim_d_n    = PWIDTH'(cfu.cmd_inputs_1);
            end
            OP_READ: begin
              state_n    = S_RD;
              pim_addr_n = row;
            end
            OP_SET: begin
              act_set     = 1'b1;
              state_n     = S_RESP;
              rsp_valid_n = 1'b1;
            end
            OP_RUN: begin
              state_n    = S_RUN;
              pim_p_en_n = 1'b1;
              pim_rwl_n  = plane;
            end
            OP_CLR: begin
              act_clr     = 1'b1;
              state_n     = S_RESP;
              rsp_valid_n = 1'b1;
            end
            default: begin
              rsp_error_n = 1'b1;
              rsp_out_n   = '1;
              state_n     = S_RESP;
              rsp_valid_n = 1'b1;
            end
          endcase
        end
      end
      S_WR: begin
        state_n     = S_RESP;
        rsp_valid_n = 1'b1;
      end
      S_RD: begin
        state_n = S_RD_CAP;
      end
      S_RD_CAP: begin
        rsp_out_n   = XW'(pim_q);
        state_n     = S_RESP;
        rsp_valid_n = 1'b1;
      end
      S_RUN: begin
        pim_p_en_n = 1'b1;
        if (cnt == CW'(ABITS - 1)) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n     = cnt + CW'(1);
          sel       = cnt + CW'(1);
          pim_rwl_n = plane;
        end
      end
      S_DRAIN: begin
        // Keep p_en high while the macro's adder tree and output register settle.
        if (cnt == CW'(DRAIN - 1)) begin
          state_n = S_CAP;
        end else begin
          cnt_n      = cnt + CW'(1);
          pim_p_en_n = 1'b1;
        end
      end
      S_CAP: begin
        rsp_out_n   = XW'(pim_mac_out);
        state_n     = S_RESP;
        rsp_valid_n = 1'b1;
      end
      S_RESP: begin
        rsp_valid_n = 1'b1;
        if (cfu.rsp_ready) begin
          state_n     = S_IDLE;
          rsp_valid_n = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    cmd_ready_n = (state_n == S_IDLE);
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      cnt               <= '0;
      cfu.cmd_ready     <= 1'b1;
      cfu.rsp_valid     <= 1'b0;
      cfu.rsp_outputs_0 <= '0;
      cfu.rsp_error     <= 1'b0;
      pim_d             <= '0;
      pim_addr          <= '0;
      pim_rwl           <= '0;
      pim_w_en          <= 1'b0;
      pim_p_en          <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      cfu.cmd_ready     <= cmd_ready_n;
      cfu.rsp_valid     <= rsp_valid_n;
      cfu.rsp_outputs_0 <= rsp_out_n;
      cfu.rsp_error     <= rsp_error_n;
      pim_d             <= pim_d_n;
      pim_addr          <= pim_addr_n;
      pim_rwl           <= pim_rwl_n;
      pim_w_en          <= pim_w_en_n;
      pim_p_en          <= pim_p_en_n;
    end
  end

endmodule

// File: tb/tb_pim_seq_ctrl.sv
// Directed bench for pim_seq_ctrl with a behavioural PIM macro (registered read,
// popcount-per-plane bit-serial MAC cleared whenever p_en is low).
module tb_pim_seq_ctrl;
  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pim_d;
  logic [7:0]   pim_addr;
  logic [255:0] pim_rwl;
  logic         pim_w_en, pim_p_en;
  logic [31:0]  pim_q = '0;
  logic [31:0]  pim_mac_out = '0;

  int checks = 0;
  int failures = 0;

  pim_seq_ctrl_if bus ();

  pim_seq_ctrl dut (
    .clk(clk), .reset(reset), .cfu(bus),
    .pim_d(pim_d), .pim_addr(pim_addr), .pim_rwl(pim_rwl),
    .pim_w_en(pim_w_en), .pim_p_en(pim_p_en),
    .pim_q(pim_q), .pim_mac_out(pim_mac_out)
  );

  always #5 clk = ~clk;

  // Macro model
  logic [31:0] mem [256] = '{default: '0};
  logic [31:0] acc = '0;
  int          pcnt = 0;
  logic [31:0] partial;

  always_comb begin
    partial = '0;
    for (int j = 0; j < 256; j++)
      if (pim_rwl[j]) partial = partial + 32'($countones(mem[j]));
  end

  always @(posedge clk) begin
    if (pim_w_en) mem[pim_addr] <= pim_d;
    pim_q <= mem[pim_addr];
    if (pim_p_en) begin
      acc  <= acc + (partial << pcnt);
      pcnt <= pcnt + 1;
    end else begin
      acc  <= '0;
      pcnt <= 0;
    end
    pim_mac_out <= acc;
  end

  // Pin activity monitor
  int         w_cnt = 0;
  int         p_cnt = 0;
  logic [1:0] rwl_log [256];

  always @(posedge clk) begin
    if (pim_w_en) w_cnt <= w_cnt + 1;
    if (pim_p_en) begin
      rwl_log[p_cnt[7:0]] <= pim_rwl[1:0];
      p_cnt <= p_cnt + 1;
    end
  end

  task automatic do_cmd(input logic [2:0] op, input logic [31:0] in0, input logic [31:0] in1,
                        output int lat, output logic [31:0] data, output logic err);
    int n;
    lat = -1; data = 'x; err = 1'bx;
    bus.cmd_function_id = op;
    bus.cmd_inputs_0    = in0;
    bus.cmd_inputs_1    = in1;
    bus.rsp_ready       = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      if (bus.rsp_valid) begin
        lat  = i;
        data = bus.rsp_outputs_0;
        err  = bus.rsp_error;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat > 0) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b1;
    bus.cmd_function_id = '0; bus.cmd_inputs_0 = '0; bus.cmd_inputs_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (bus.rsp_outputs_0 !== 32'h0 || bus.rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%h/%b exp=0/0", bus.rsp_outputs_0, bus.rsp_error); end
    checks++; if ({pim_w_en, pim_p_en} !== 2'b00 || pim_rwl !== '0) begin failures++; $display("FAIL reset_pins got w=%b p=%b rwl=%h exp=0", pim_w_en, pim_p_en, pim_rwl); end
    checks++; if (pim_addr !== 8'h0 || pim_d !== 32'h0) begin failures++; $display("FAIL reset_addr_d got=%h/%h exp=0/0", pim_addr, pim_d); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] d; logic e;
    do_cmd(3'd0, 32'd5, 32'hDEAD_BEEF, lat, d, e);
    checks++; if (lat !== 2) begin failures++; $display("FAIL write_latency got=%0d exp=2", lat); end
    checks++; if (d !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL write_rsp got=%h/%b exp=0/0", d, e); end
    checks++; if (pim_addr !== 8'd5 || pim_d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL write_pins got=%h/%h exp=05/deadbeef", pim_addr, pim_d); end
    do_cmd(3'd1, 32'd5, 32'h0, lat, d, e);
    checks++; if (lat !== 3) begin failures++; $display("FAIL read_latency got=%0d exp=3", lat); end
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_data got=%h exp=deadbeef", d); end
    // upper index bits ignored: row 0x109 aliases row 9
    do_cmd(3'd0, 32'h0000_0109, 32'h1234_5678, lat, d, e);
    do_cmd(3'd1, 32'd9, 32'h0, lat, d, e);
    checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL read_wrap got=%h exp=12345678", d); end
  endtask

  task automatic test_run();
    int lat; logic [31:0] d; logic e; int base;
    do_cmd(3'd0, 32'd0, 32'd3, lat, d, e);
    do_cmd(3'd0, 32'd1, 32'd1, lat, d, e);
    do_cmd(3'd2, 32'd0, 32'd2, lat, d, e);
    checks++; if (lat !== 1 || d !== 32'h0) begin failures++; $display("FAIL set_act_rsp got lat=%0d d=%h exp=1/0", lat, d); end
    do_cmd(3'd2, 32'd1, 32'd3, lat, d, e);
    base = p_cnt;
    do_cmd(3'd3, 32'd0, 32'd0, lat, d, e);
    checks++; if (lat !== 8) begin failures++; $display("FAIL run_latency got=%0d exp=8", lat); end
    checks++; if (d !== 32'd7) begin failures++; $display("FAIL run_result got=%0d exp=7", d); end
    checks++; if (p_cnt - base !== 6) begin failures++; $display("FAIL run_p_en_cycles got=%0d exp=6", p_cnt - base); end
    checks++;
    if (rwl_log[8'(base)] !== 2'b10 || rwl_log[8'(base+1)] !== 2'b11 ||
        rwl_log[8'(base+2)] !== 2'b00 || rwl_log[8'(base+3)] !== 2'b00 ||
        rwl_log[8'(base+4)] !== 2'b00 || rwl_log[8'(base+5)] !== 2'b00) begin
      failures++;
      $display("FAIL run_rwl_seq got=%b,%b,%b,%b,%b,%b exp=10,11,00,00,00,00",
               rwl_log[8'(base)], rwl_log[8'(base+1)], rwl_log[8'(base+2)],
               rwl_log[8'(base+3)], rwl_log[8'(base+4)], rwl_log[8'(base+5)]);
    end
    checks++; if (pim_p_en !== 1'b0 || pim_rwl !== '0) begin failures++; $display("FAIL run_idle_pins got p=%b rwl=%h exp=0", pim_p_en, pim_rwl); end
    do_cmd(3'd3, 32'd0, 32'd0, lat, d, e);
    checks++; if (d !== 32'd7) begin failures++; $display("FAIL run_repeat got=%0d exp=7", d); end
  endtask

  task automatic test_overwrite();
    int lat; logic [31:0] d; logic e;
    // act0 becomes 1 (upper operand bits dropped); plane0 rows{0,1}=3, plane1 row1=1 -> 3+2
    do_cmd(3'd2, 32'd0, 32'h0000_FFF1, lat, d, e);
    do_cmd(3'd3, 32'd0, 32'd0, lat, d, e);
    checks++; if (d !== 32'd5) begin failures++; $display("FAIL set_act_overwrite got=%0d exp=5", d); end
  endtask

  task automatic test_clr_act();
    int lat; logic [31:0] d; logic e;
    do_cmd(3'd4, 32'd0, 32'd0, lat, d, e);
    checks++; if (lat !== 1 || d !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL clr_act_rsp got lat=%0d d=%h e=%b exp=1/0/0", lat, d, e); end
    do_cmd(3'd3, 32'd0, 32'd0, lat, d, e);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL run_after_clr got=%0d exp=0", d); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] d; logic e; int wb, pb;
    wb = w_cnt; pb = p_cnt;
    do_cmd(3'd6, 32'd3, 32'h55, lat, d, e);
    checks++; if (e !== 1'b1 || d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL illegal_rsp got=%h/%b exp=ffffffff/1", d, e); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
    checks++; if (w_cnt !== wb || p_cnt !== pb) begin failures++; $display("FAIL illegal_pins got w=%0d p=%0d exp=0/0", w_cnt - wb, p_cnt - pb); end
    do_cmd(3'd0, 32'd20, 32'hCAFE, lat, d, e);
    checks++; if (e !== 1'b0 || d !== 32'h0) begin failures++; $display("FAIL error_cleared got=%h/%b exp=0/0", d, e); end
  endtask

  task automatic test_stall();
    int lat; logic [31:0] d; logic e; int n; int wb;
    do_cmd(3'd2, 32'd0, 32'd2, lat, d, e);
    do_cmd(3'd2, 32'd1, 32'd3, lat, d, e);
    bus.rsp_ready = 1'b0;
    bus.cmd_function_id = 3'd3;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_rsp_timeout got=%b exp=1", bus.rsp_valid); end
    checks++; if (bus.rsp_outputs_0 !== 32'd7) begin failures++; $display("FAIL stall_run_result got=%0d exp=7", bus.rsp_outputs_0); end
    wb = w_cnt;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        bus.cmd_function_id = 3'd0; bus.cmd_inputs_0 = 32'd7; bus.cmd_inputs_1 = 32'hAAAA;
        bus.cmd_valid = 1'b1;
      end
      if (i == 5) bus.cmd_valid = 1'b0;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_outputs_0 !== 32'd7 || bus.cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got v=%b d=%0d rdy=%b exp=1/7/0", i, bus.rsp_valid, bus.rsp_outputs_0, bus.cmd_ready);
      end
    end
    checks++; if (w_cnt !== wb) begin failures++; $display("FAIL stall_no_accept got w_en cycles=%0d exp=0", w_cnt - wb); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL stall_release got v=%b rdy=%b exp=0/1", bus.rsp_valid, bus.cmd_ready); end
    do_cmd(3'd1, 32'd7, 32'd0, lat, d, e);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL stall_dropped_write got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [31:0] d; logic e;
    bus.rsp_ready = 1'b1;
    bus.cmd_function_id = 3'd3;
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++; if (pim_p_en !== 1'b1) begin failures++; $display("FAIL mid_run_active got p=%b exp=1", pim_p_en); end
    reset = 1'b1;
    #1;
    checks++; if (pim_p_en !== 1'b0 || pim_rwl !== '0 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_run_reset got p=%b rwl=%h v=%b exp=0/0/0", pim_p_en, pim_rwl, bus.rsp_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL post_reset got rdy=%b v=%b exp=1/0", bus.cmd_ready, bus.rsp_valid); end
    do_cmd(3'd3, 32'd0, 32'd0, lat, d, e);
    checks++; if (d !== 32'd0 || lat !== 8) begin failures++; $display("FAIL post_reset_run got d=%0d lat=%0d exp=0/8", d, lat); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_run();
    test_overwrite();
    test_clr_act();
    test_illegal();
    test_stall();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
